// File: rtl/sprite_pkg.sv
// sprite_pkg: shared types and 1080p timing constants for the sprite motion
// controller and its helpers.
package sprite_pkg;

  // Screen coordinate width and the coordinate type built from it
  localparam int CORDW = 12;
  typedef logic [CORDW-1:0] coord_t;

  // 1080p60 raster (active and total sizes)
  localparam int H_RES      = 1920;
  localparam int V_RES      = 1080;
  localparam int H_RES_FULL = 2200;
  localparam int V_RES_FULL = 1125;

  // Position update sequencer: idle, then one cycle per axis
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVE_X = 2'd1,
    MOVE_Y = 2'd2
  } state_e;

endpackage

// File: rtl/sprite_axis_step.sv
// sprite_axis_step: combinational single-axis clamp/bounce step.
// Moving forward (i_dir=1) the position grows by i_speed and clamps at
// i_limit, reversing direction there. Moving backward it shrinks by i_speed
// and clamps at 0, reversing direction there. The forward sum is formed one
// bit wider so it cannot wrap before the compare.
module sprite_axis_step #(
  parameter int CORDW = 12
) (
  input  logic [CORDW-1:0] i_pos,
  input  logic             i_dir,
  input  logic [CORDW-1:0] i_speed,
  input  logic [CORDW-1:0] i_limit,
  output logic [CORDW-1:0] o_pos,
  output logic             o_dir
);

  logic [CORDW:0] w_sum;

  assign w_sum = {1'b0, i_pos} + {1'b0, i_speed};

  // Next position and direction for one step along this axis
  always_comb begin
    o_pos = i_pos;
    o_dir = i_dir;
    if (i_dir) begin
      if (w_sum >= {1'b0, i_limit}) begin
        o_pos = i_limit;
        o_dir = 1'b0;
      end else begin
        o_pos = w_sum[CORDW-1:0];
      end
    end else begin
      if (i_pos <= i_speed) begin
        o_pos = '0;
        o_dir = 1'b1;
      end else begin
        o_pos = i_pos - i_speed;
      end
    end
  end

endmodule

// File: rtl/sprite_motion_ctrl.sv
// sprite_motion_ctrl: owns one sprite's screen position, moves it once per
// frame during vertical blanking with edge bounce, and issues the sprite
// engine's start pulse in the horizontal blanking of the line before the
// first drawn line.
// Optional build macro SPRITE_MOTION_FRAMEDIV_EN: update only every
// FRAME_DIV frames (counted while move_en is high).
module sprite_motion_ctrl #(
  parameter int CORDW      = sprite_pkg::CORDW,
  parameter int H_RES      = sprite_pkg::H_RES,
  parameter int V_RES      = sprite_pkg::V_RES,
  parameter int V_RES_FULL = sprite_pkg::V_RES_FULL,
  parameter int SPR_W_PIX  = 240,
  parameter int SPR_H_PIX  = 240,
  parameter int START_X    = 840,
  parameter int START_Y    = 420,
  parameter int SPEED_X    = 4,
  parameter int SPEED_Y    = 2
`ifdef SPRITE_MOTION_FRAMEDIV_EN
  ,
  parameter int FRAME_DIV  = 4
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CORDW-1:0] sx,
  input  logic [CORDW-1:0] sy,
  input  logic             move_en,
  output logic [CORDW-1:0] sprx,
  output logic [CORDW-1:0] spry,
  output logic             start,
  output logic             frame,
  output logic             dir_x,
  output logic             dir_y
);

  import sprite_pkg::*;

  // Raster constants at coordinate width
  localparam logic [CORDW-1:0] L_V_RES     = CORDW'(V_RES);
  localparam logic [CORDW-1:0] L_H_LAST    = CORDW'(H_RES - 1);
  localparam logic [CORDW-1:0] L_V_LAST    = CORDW'(V_RES_FULL - 1);
  localparam logic [CORDW-1:0] L_LIMIT_X   = CORDW'(H_RES - SPR_W_PIX);
  localparam logic [CORDW-1:0] L_LIMIT_Y   = CORDW'(V_RES - SPR_H_PIX);
  localparam logic [CORDW-1:0] L_SPEED_X   = CORDW'(SPEED_X);
  localparam logic [CORDW-1:0] L_SPEED_Y   = CORDW'(SPEED_Y);
  localparam logic [CORDW-1:0] L_START_X   = CORDW'(START_X);
  localparam logic [CORDW-1:0] L_START_Y   = CORDW'(START_Y);
  localparam logic [CORDW-1:0] L_COR_RESET =
    (START_Y == 0) ? CORDW'(V_RES_FULL - 1) : CORDW'(START_Y - 1);

  state_e           r_state;
  state_e           w_state_next;
  logic [CORDW-1:0] r_sprx;
  logic [CORDW-1:0] r_spry;
  logic             r_dir_x;
  logic             r_dir_y;
  logic [CORDW-1:0] r_spry_cor;
  logic             r_start;
  logic             r_frame;
  logic             w_div_ok;
  logic [CORDW-1:0] w_x_pos;
  logic             w_x_dir;
  logic [CORDW-1:0] w_y_pos;
  logic             w_y_dir;

`ifdef SPRITE_MOTION_FRAMEDIV_EN
  localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [DIV_W-1:0] L_DIV_LAST = DIV_W'(FRAME_DIV - 1);

  logic [DIV_W-1:0] r_div_cnt;

  // Count enabled frames; wraps on the frame that triggers an update
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_cnt <= '0;
    end else if (r_frame && move_en) begin
      r_div_cnt <= (r_div_cnt == L_DIV_LAST) ? '0 : r_div_cnt + 1'b1;
    end
  end

  assign w_div_ok = (r_div_cnt == L_DIV_LAST);
`else
  assign w_div_ok = 1'b1;
`endif

  // Per-axis bounce logic, evaluated from the current position
  sprite_axis_step #(.CORDW(CORDW)) u_step_x (
    .i_pos   (r_sprx),
    .i_dir   (r_dir_x),
    .i_speed (L_SPEED_X),
    .i_limit (L_LIMIT_X),
    .o_pos   (w_x_pos),
    .o_dir   (w_x_dir)
  );

  sprite_axis_step #(.CORDW(CORDW)) u_step_y (
    .i_pos   (r_spry),
    .i_dir   (r_dir_y),
    .i_speed (L_SPEED_Y),
    .i_limit (L_LIMIT_Y),
    .o_pos   (w_y_pos),
    .o_dir   (w_y_dir)
  );

  // Frame strobe: one cycle after the first pixel of vertical blanking
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame <= 1'b0;
    end else begin
      r_frame <= (sy == L_V_RES) && (sx == '0);
    end
  end

  // Update sequencer state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Update sequencer next state: move_en only matters in the frame cycle
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (r_frame && move_en && w_div_ok) w_state_next = MOVE_X;
      MOVE_X:  w_state_next = MOVE_Y;
      MOVE_Y:  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Position and direction: x commits in MOVE_X, y commits in MOVE_Y
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sprx  <= L_START_X;
      r_spry  <= L_START_Y;
      r_dir_x <= 1'b1;
      r_dir_y <= 1'b1;
    end else begin
      if (r_state == MOVE_X) begin
        r_sprx  <= w_x_pos;
        r_dir_x <= w_x_dir;
      end
      if (r_state == MOVE_Y) begin
        r_spry  <= w_y_pos;
        r_dir_y <= w_y_dir;
      end
    end
  end

  // Line before the sprite's top line; a top line of 0 wraps to the last
  // line of the previous frame, which follows the update in time
  always_ff @(posedge clk) begin
    if (rst) begin
      r_spry_cor <= L_COR_RESET;
    end else begin
      r_spry_cor <= (r_spry == '0) ? L_V_LAST : r_spry - 1'b1;
    end
  end

  // Start pulse lands on the first horizontal blanking pixel of that line
  always_ff @(posedge clk) begin
    if (rst) begin
      r_start <= 1'b0;
    end else begin
      r_start <= (sy == r_spry_cor) && (sx == L_H_LAST);
    end
  end

  assign sprx  = r_sprx;
  assign spry  = r_spry;
  assign start = r_start;
  assign frame = r_frame;
  assign dir_x = r_dir_x;
  assign dir_y = r_dir_y;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// tb_sprite_motion_ctrl: directed, table-driven bench for sprite_motion_ctrl.
// sx/sy are driven straight to the raster points of interest instead of
// sweeping whole frames. A second instance with different start/speed
// parameters exercises both edge bounces and the spry==0 wrap.
module tb_sprite_motion_ctrl;

  import sprite_pkg::*;

  typedef struct {
    logic [11:0] sx;
    logic [11:0] sy;
    logic        me;
    logic [11:0] sprx;
    logic [11:0] spry;
    logic        st;
    logic        fr;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] sx;
  logic [11:0] sy;
  logic        move_en;

  logic [11:0] sprx, spry;
  logic        start, frame, dir_x, dir_y;
  logic [11:0] sprx2, spry2;
  logic        start2, frame2, dir_x2, dir_y2;

  int n_cmp = 0;
  int n_bad = 0;

  vec_t vecs[$];

  always #5 clk = ~clk;

  sprite_motion_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .sx      (sx),
    .sy      (sy),
    .move_en (move_en),
    .sprx    (sprx),
    .spry    (spry),
    .start   (start),
    .frame   (frame),
    .dir_x   (dir_x),
    .dir_y   (dir_y)
  );

  // Starts 4 px short of the right limit (1680) and 2 lines short of the
  // bottom limit (840); SPEED_Y=840 then bounces y straight back to 0
  sprite_motion_ctrl #(
    .START_X (1676),
    .START_Y (838),
    .SPEED_Y (840)
  ) dut2 (
    .clk     (clk),
    .rst     (rst),
    .sx      (sx),
    .sy      (sy),
    .move_en (move_en),
    .sprx    (sprx2),
    .spry    (spry2),
    .start   (start2),
    .frame   (frame2),
    .dir_x   (dir_x2),
    .dir_y   (dir_y2)
  );

  task automatic push(input logic [11:0] a_sx, input logic [11:0] a_sy,
                      input logic a_me, input logic [11:0] a_sprx,
                      input logic [11:0] a_spry, input logic a_st,
                      input logic a_fr);
    vec_t v;
    v.sx = a_sx; v.sy = a_sy; v.me = a_me;
    v.sprx = a_sprx; v.spry = a_spry; v.st = a_st; v.fr = a_fr;
    vecs.push_back(v);
  endtask

  // Drive inputs, clock once, sample 1 time unit after the edge
  task automatic step(input logic [11:0] a_sx, input logic [11:0] a_sy,
                      input logic a_me);
    sx = a_sx;
    sy = a_sy;
    move_en = a_me;
    @(posedge clk);
    #1;
  endtask

  task automatic chkw(input string name, input logic [11:0] act,
                      input logic [11:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0b, expected %0b", name, act, exp);
    end
  endtask

  initial begin
    // row: sx, sy, move_en | expected sprx, spry, start, frame
    push(0,    0,    1'b0, 840, 420, 1'b0, 1'b0);
    push(1919, 419,  1'b0, 840, 420, 1'b1, 1'b0);  // start for top line 420
    push(1920, 419,  1'b0, 840, 420, 1'b0, 1'b0);  // single cycle
    push(1919, 418,  1'b0, 840, 420, 1'b0, 1'b0);  // wrong line
    push(1918, 419,  1'b0, 840, 420, 1'b0, 1'b0);  // wrong pixel
    push(0,    1080, 1'b0, 840, 420, 1'b0, 1'b1);  // frame strobe
    push(1,    1080, 1'b0, 840, 420, 1'b0, 1'b0);  // move_en low: no update
    push(2,    1080, 1'b0, 840, 420, 1'b0, 1'b0);
    push(3,    1080, 1'b0, 840, 420, 1'b0, 1'b0);
    push(0,    1079, 1'b0, 840, 420, 1'b0, 1'b0);  // wrong line: no frame
    push(1,    1080, 1'b0, 840, 420, 1'b0, 1'b0);  // wrong pixel: no frame
    // three enabled updates
    push(0,    1080, 1'b1, 840, 420, 1'b0, 1'b1);
    push(1,    1080, 1'b1, 840, 420, 1'b0, 1'b0);
    push(2,    1080, 1'b1, 844, 420, 1'b0, 1'b0);
    push(3,    1080, 1'b1, 844, 422, 1'b0, 1'b0);
    push(4,    1080, 1'b1, 844, 422, 1'b0, 1'b0);
    push(0,    1080, 1'b1, 844, 422, 1'b0, 1'b1);
    push(1,    1080, 1'b1, 844, 422, 1'b0, 1'b0);
    push(2,    1080, 1'b1, 848, 422, 1'b0, 1'b0);
    push(3,    1080, 1'b1, 848, 424, 1'b0, 1'b0);
    push(0,    1080, 1'b1, 848, 424, 1'b0, 1'b1);
    push(1,    1080, 1'b1, 848, 424, 1'b0, 1'b0);
    push(2,    1080, 1'b1, 852, 424, 1'b0, 1'b0);
    push(3,    1080, 1'b1, 852, 426, 1'b0, 1'b0);
    // move_en low only in the frame cycle: no update
    push(0,    1080, 1'b1, 852, 426, 1'b0, 1'b1);
    push(1,    1080, 1'b0, 852, 426, 1'b0, 1'b0);
    push(2,    1080, 1'b1, 852, 426, 1'b0, 1'b0);
    push(3,    1080, 1'b1, 852, 426, 1'b0, 1'b0);
    // start follows the new top line 426
    push(1919, 425,  1'b0, 852, 426, 1'b1, 1'b0);
    push(1919, 419,  1'b0, 852, 426, 1'b0, 1'b0);
    push(1920, 425,  1'b0, 852, 426, 1'b0, 1'b0);

    $display("raster %0dx%0d of %0dx%0d, %0d vectors",
             H_RES, V_RES, H_RES_FULL, V_RES_FULL, vecs.size());

    // Reset state
    rst = 1'b1;
    step(0, 0, 1'b0);
    step(0, 0, 1'b0);
    chkw("reset sprx", sprx, 840);
    chkw("reset spry", spry, 420);
    chkb("reset start", start, 1'b0);
    chkb("reset frame", frame, 1'b0);
    chkb("reset dir_x", dir_x, 1'b1);
    chkb("reset dir_y", dir_y, 1'b1);
    chkw("reset sprx2", sprx2, 1676);
    chkw("reset spry2", spry2, 838);
    rst = 1'b0;

    // Table-driven vectors
    foreach (vecs[i]) begin
      step(vecs[i].sx, vecs[i].sy, vecs[i].me);
      $display("row %0d sx=%0d sy=%0d en=%0b -> sprx=%0d spry=%0d start=%0b frame=%0b",
               i, vecs[i].sx, vecs[i].sy, vecs[i].me, sprx, spry, start, frame);
      chkw($sformatf("row%0d sprx", i), sprx, vecs[i].sprx);
      chkw($sformatf("row%0d spry", i), spry, vecs[i].spry);
      chkb($sformatf("row%0d start", i), start, vecs[i].st);
      chkb($sformatf("row%0d frame", i), frame, vecs[i].fr);
    end
    chkb("table dir_x", dir_x, 1'b1);
    chkb("table dir_y", dir_y, 1'b1);

    // Reset asserted while the sequencer is in MOVE_X
    step(0, 1080, 1'b1);
    step(1, 1080, 1'b1);
    rst = 1'b1;
    step(1919, 425, 1'b1);  // would otherwise raise start (cor line 425)
    $display("mid-update reset -> sprx=%0d spry=%0d start=%0b", sprx, spry, start);
    chkw("midrst sprx", sprx, 840);
    chkw("midrst spry", spry, 420);
    chkb("midrst start", start, 1'b0);
    chkb("midrst frame", frame, 1'b0);
    chkb("midrst dir_x", dir_x, 1'b1);
    chkb("midrst dir_y", dir_y, 1'b1);
    rst = 1'b0;
    step(2, 1080, 1'b1);
    step(3, 1080, 1'b1);
    chkw("midrst idle sprx", sprx, 840);
    chkw("midrst idle spry", spry, 420);
    step(1919, 419, 1'b0);
    chkb("midrst start line", start, 1'b1);

    // dut2 update 1: x clamps at 1680, y clamps at 840, both reverse
    step(0, 1080, 1'b1);
    chkb("bounce frame2", frame2, 1'b1);
    step(1, 1080, 1'b1);
    step(2, 1080, 1'b1);
    step(3, 1080, 1'b1);
    $display("bounce1 -> sprx2=%0d dir_x2=%0b spry2=%0d dir_y2=%0b",
             sprx2, dir_x2, spry2, dir_y2);
    chkw("bounce1 sprx2", sprx2, 1680);
    chkb("bounce1 dir_x2", dir_x2, 1'b0);
    chkw("bounce1 spry2", spry2, 840);
    chkb("bounce1 dir_y2", dir_y2, 1'b0);
    chkw("bounce1 sprx", sprx, 844);

    // dut2 update 2: x moves left to 1676, y clamps at 0 and turns down
    step(0, 1080, 1'b1);
    step(1, 1080, 1'b1);
    step(2, 1080, 1'b1);
    step(3, 1080, 1'b1);
    $display("bounce2 -> sprx2=%0d dir_x2=%0b spry2=%0d dir_y2=%0b",
             sprx2, dir_x2, spry2, dir_y2);
    chkw("bounce2 sprx2", sprx2, 1676);
    chkb("bounce2 dir_x2", dir_x2, 1'b0);
    chkw("bounce2 spry2", spry2, 0);
    chkb("bounce2 dir_y2", dir_y2, 1'b1);

    // spry2==0: start fires on the last line of the raster
    step(0, 0, 1'b0);
    step(1919, 1123, 1'b0);
    chkb("wrap start early line", start2, 1'b0);
    step(1919, 1124, 1'b0);
    $display("wrap -> start2=%0b at sy=1124 sx=1920", start2);
    chkb("wrap start", start2, 1'b1);
    step(1920, 1124, 1'b0);
    chkb("wrap start one cycle", start2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
